// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Write-enable / flush strobes for every pipeline register plus the PC.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic exmem_flush;
        logic memwb_we;
    } strobe_t;

    localparam strobe_t STROBE_DEFAULT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                           idex_we: 1'b1, idex_flush: 1'b0,
                                           exmem_we: 1'b1, exmem_flush: 1'b0, memwb_we: 1'b1};

    // Hold IF and ID, send a bubble into EX.
    localparam strobe_t STROBE_LOADUSE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                           idex_we: 1'b1, idex_flush: 1'b1,
                                           exmem_we: 1'b1, exmem_flush: 1'b0, memwb_we: 1'b1};

    // Squash the two wrong-path instructions in IF/ID and ID/EX.
    localparam strobe_t STROBE_BRANCH  = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                           idex_we: 1'b1, idex_flush: 1'b1,
                                           exmem_we: 1'b1, exmem_flush: 1'b0, memwb_we: 1'b1};

    // Freeze IF/ID/EX while the mul/div occupies EX; bubble into MEM.
    localparam strobe_t STROBE_MDSTALL = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                           idex_we: 1'b0, idex_flush: 1'b0,
                                           exmem_we: 1'b1, exmem_flush: 1'b1, memwb_we: 1'b1};

    // True when the ID instruction really reads source rs and it names rd.
    function automatic logic src_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses & (rs == rd);
    endfunction

endpackage

// File: rtl/md_stall_timer.sv
// Tracks mul/div occupancy of EX: RUN / MD_BUSY state plus down-counter.
module md_stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic Rst,
    input  logic md_start,
    output logic md_busy,
    output logic md_release
);

    // Start cycle already counts as one stall, so the counter loads MD_LAT-2.
    localparam int         MD_INIT_I   = (MD_LAT >= 2) ? (MD_LAT - 2) : 0;
    localparam logic [3:0] MD_INIT     = MD_INIT_I[3:0];
    localparam logic       MD_STALL_EN = (MD_LAT >= 2);

    md_state_e  state_r, state_s;
    logic [3:0] md_cnt_r, md_cnt_s;
    logic       md_busy_s;

    // Next-state, counter update and busy/release decode.
    always_comb begin
        state_s      = state_r;
        md_cnt_s     = md_cnt_r;
        md_busy_s    = 1'b0;
        md_release   = 1'b0;
        case (state_r)
            RUN: begin
                if (md_start && MD_STALL_EN) begin
                    md_busy_s = 1'b1;
                    state_s   = MD_BUSY;
                    md_cnt_s  = MD_INIT;
                end else begin
                    state_s   = RUN;
                end
            end
            MD_BUSY: begin
                if (md_cnt_r != 4'd0) begin
                    md_busy_s = 1'b1;
                    md_cnt_s  = md_cnt_r - 4'd1;
                end else begin
                    md_release = 1'b1;
                    state_s    = RUN;
                end
            end
            default: begin
                state_s  = RUN;
                md_cnt_s = 4'd0;
            end
        endcase
    end

    // Reset forces busy low immediately, not just at the next edge.
    assign md_busy = md_busy_s & ~Rst;

    // State and counter registers; reset aborts any count in progress.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_r  <= RUN;
            md_cnt_r <= 4'd0;
        end else begin
            state_r  <= state_s;
            md_cnt_r <= md_cnt_s;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, taken branch and mul/div hazards.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             memwb_we,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             md_busy_s;
    logic             md_release_s;
    logic             load_use_s;
    strobe_t          strobe_s;
    logic [CNT_W-1:0] stall_cycles_r;

    md_stall_timer #(
        .MD_LAT(MD_LAT)
    ) u_md_timer (
        .clk       (clk),
        .Rst       (Rst),
        .md_start  (ex_md_start),
        .md_busy   (md_busy_s),
        .md_release(md_release_s)
    );

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign load_use_s = ex_mem_read & (ex_rd != REG_ZERO) &
                        (src_match(id_uses_rs1, id_rs1, ex_rd) | src_match(id_uses_rs2, id_rs2, ex_rd));

    // Priority mux: reset > mul/div > release > branch > load-use > default.
    always_comb begin
        strobe_s = STROBE_DEFAULT;
        if (Rst) begin
            strobe_s = STROBE_DEFAULT;
        end else if (md_busy_s) begin
            strobe_s = STROBE_MDSTALL;
        end else if (md_release_s) begin
            strobe_s = STROBE_DEFAULT;
        end else if (ex_md_start) begin
            // Single-cycle mul/div: no stall, and a stray branch is dropped.
            strobe_s = STROBE_DEFAULT;
        end else if (ex_branch_taken) begin
            strobe_s = STROBE_BRANCH;
        end else if (load_use_s) begin
            strobe_s = STROBE_LOADUSE;
        end else begin
            strobe_s = STROBE_DEFAULT;
        end
    end

    assign pc_we        = strobe_s.pc_we;
    assign ifid_we      = strobe_s.ifid_we;
    assign ifid_flush   = strobe_s.ifid_flush;
    assign idex_we      = strobe_s.idex_we;
    assign idex_flush   = strobe_s.idex_flush;
    assign exmem_we     = strobe_s.exmem_we;
    assign exmem_flush  = strobe_s.exmem_flush;
    assign memwb_we     = strobe_s.memwb_we;
    assign md_busy      = md_busy_s;
    assign stall_cycles = stall_cycles_r;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!strobe_s.pc_we && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MD_LAT=4/CNT_W=16 and MD_LAT=1/CNT_W=2).
module tb_pipe_hazard_ctrl;

    // Bit order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we
    localparam logic [7:0] S_DEF = 8'b1101_0101;
    localparam logic [7:0] S_LU  = 8'b0001_1101;
    localparam logic [7:0] S_BR  = 8'b1111_1101;
    localparam logic [7:0] S_MD  = 8'b0000_0111;

    typedef struct packed {
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       br;
        logic       md;
        logic [7:0] st;
        logic       busy;
    } stim_t;

    logic clk, Rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_md_start;

    logic a_pc_we, a_ifid_we, a_ifid_flush, a_idex_we, a_idex_flush;
    logic a_exmem_we, a_exmem_flush, a_memwb_we, a_md_busy;
    logic [15:0] a_stall;
    logic b_pc_we, b_ifid_we, b_ifid_flush, b_idex_we, b_idex_flush;
    logic b_exmem_we, b_exmem_flush, b_memwb_we, b_md_busy;
    logic [1:0] b_stall;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_st1 = 0;
    int exp_st2 = 0;
    logic [24:0] exp_q[$];
    logic [24:0] e;

    pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .Rst(Rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush),
        .idex_we(a_idex_we), .idex_flush(a_idex_flush), .exmem_we(a_exmem_we),
        .exmem_flush(a_exmem_flush), .memwb_we(a_memwb_we), .md_busy(a_md_busy),
        .stall_cycles(a_stall)
    );

    pipe_hazard_ctrl #(.MD_LAT(1), .CNT_W(2)) dut_b (
        .clk(clk), .Rst(Rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush),
        .idex_we(b_idex_we), .idex_flush(b_idex_flush), .exmem_we(b_exmem_we),
        .exmem_flush(b_exmem_flush), .memwb_we(b_memwb_we), .md_busy(b_md_busy),
        .stall_cycles(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] obs_a();
        return {a_pc_we, a_ifid_we, a_ifid_flush, a_idex_we, a_idex_flush,
                a_exmem_we, a_exmem_flush, a_memwb_we, a_md_busy, a_stall};
    endfunction

    function automatic logic [24:0] obs_b();
        return {b_pc_we, b_ifid_we, b_ifid_flush, b_idex_we, b_idex_flush,
                b_exmem_we, b_exmem_flush, b_memwb_we, b_md_busy, 14'd0, b_stall};
    endfunction

    function automatic stim_t mk(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic u1, input logic [4:0] rs2, input logic u2,
                                 input logic br, input logic md, input logic [7:0] st, input logic busy);
        stim_t s;
        s.ld = ld; s.rd = rd; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.br = br; s.md = md; s.st = st; s.busy = busy;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        ex_mem_read = s.ld; ex_rd = s.rd; id_rs1 = s.rs1; id_uses_rs1 = s.u1;
        id_rs2 = s.rs2; id_uses_rs2 = s.u2; ex_branch_taken = s.br; ex_md_start = s.md;
    endtask

    task automatic push_a(input logic [7:0] st, input logic busy);
        logic [31:0] c;
        c = exp_st1;
        exp_q.push_back({st, busy, c[15:0]});
    endtask

    task automatic push_b(input logic [7:0] st, input logic busy);
        logic [31:0] c;
        c = exp_st2;
        exp_q.push_back({st, busy, 14'd0, c[1:0]});
    endtask

    // Advance past the next rising edge and update the expected stall counts.
    task automatic tick(input logic pcwe);
        @(posedge clk);
        #1;
        if (!pcwe) begin
            exp_st1 = (exp_st1 < 65535) ? exp_st1 + 1 : 65535;
            exp_st2 = (exp_st2 < 3) ? exp_st2 + 1 : 3;
        end
    endtask

    task automatic test_reset();
        stim_t z;
        z = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0);
        Rst = 1'b1;
        apply(mk(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, S_DEF, 1'b0));
        #3;
        exp_st1 = 0; exp_st2 = 0;
        push_a(S_DEF, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL reset_a: got %h want %h", obs_a(), e); end
        push_b(S_DEF, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_b() !== e) begin n_fail++; $display("FAIL reset_b: got %h want %h", obs_b(), e); end
        @(posedge clk); #1;
        push_a(S_DEF, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs_a(), e); end
        @(negedge clk);
        Rst = 1'b0;
        apply(z);
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, S_LU, 1'b0));
        sq.push_back(mk(1'b0, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, S_DEF, 1'b0));
        sq.push_back(mk(1'b1, 5'd31, 5'd31, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, S_LU, 1'b0));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        foreach (sq[i]) begin
            apply(sq[i]);
            push_a(sq[i].st, sq[i].busy);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL load_use[%0d]: got %h want %h", i, obs_a(), e); end
            tick(sq[i].st[7]);
        end
    endtask

    task automatic test_no_hazard();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, S_DEF, 1'b0));
        sq.push_back(mk(1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        sq.push_back(mk(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, S_DEF, 1'b0));
        sq.push_back(mk(1'b1, 5'd7, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, S_DEF, 1'b0));
        foreach (sq[i]) begin
            apply(sq[i]);
            push_a(sq[i].st, sq[i].busy);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL no_hazard[%0d]: got %h want %h", i, obs_a(), e); end
            tick(sq[i].st[7]);
        end
    endtask

    task automatic test_branch();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, S_BR, 1'b0));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, S_BR, 1'b0));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        foreach (sq[i]) begin
            apply(sq[i]);
            push_a(sq[i].st, sq[i].busy);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL branch[%0d]: got %h want %h", i, obs_a(), e); end
            tick(sq[i].st[7]);
        end
    endtask

    // Held ex_md_start: 3 stalls, release (hazard inputs ignored), immediate restart.
    task automatic test_back_to_back();
        stim_t sq[$];
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_MD, 1'b1));
            end
            sq.push_back(mk(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, S_DEF, 1'b0));
        end
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        foreach (sq[i]) begin
            apply(sq[i]);
            push_a(sq[i].st, sq[i].busy);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs_a(), e); end
            tick(sq[i].st[7]);
        end
    endtask

    // md_start with branch: mul/div wins; load in release EX caught next RUN cycle.
    task automatic test_md_priority();
        stim_t sq[$];
        sq.push_back(mk(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, S_MD, 1'b1));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_MD, 1'b1));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_MD, 1'b1));
        sq.push_back(mk(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        sq.push_back(mk(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_LU, 1'b0));
        sq.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0));
        foreach (sq[i]) begin
            apply(sq[i]);
            push_a(sq[i].st, sq[i].busy);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL md_priority[%0d]: got %h want %h", i, obs_a(), e); end
            tick(sq[i].st[7]);
        end
    endtask

    task automatic test_reset_mid_md();
        stim_t md1, lu, z;
        md1 = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_MD, 1'b1);
        lu  = mk(1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, S_LU, 1'b0);
        z   = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, S_DEF, 1'b0);
        apply(md1);
        for (int j = 0; j < 2; j++) begin
            push_a(S_MD, 1'b1);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_a() !== e) begin n_fail++; $display("FAIL rst_md_pre[%0d]: got %h want %h", j, obs_a(), e); end
            tick(1'b0);
        end
        apply(z);
        push_a(S_MD, 1'b1);
        #2;
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL rst_md_busy2: got %h want %h", obs_a(), e); end
        Rst = 1'b1;
        #1;
        exp_st1 = 0;
        push_a(S_DEF, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL rst_md_async: got %h want %h", obs_a(), e); end
        @(posedge clk); #1;
        @(negedge clk);
        Rst = 1'b0;
        apply(lu);
        #1;
        push_a(S_LU, 1'b0);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL rst_md_run: got %h want %h", obs_a(), e); end
        tick(1'b0);
        apply(z);
        push_a(S_DEF, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs_a() !== e) begin n_fail++; $display("FAIL rst_md_after: got %h want %h", obs_a(), e); end
        tick(1'b1);
    endtask

    // MD_LAT=1 instance: mul/div never stalls; 5 load-use stalls saturate a 2-bit counter.
    task automatic test_saturate();
        stim_t lu, md1;
        lu  = mk(1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, S_LU, 1'b0);
        md1 = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, S_DEF, 1'b0);
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        exp_st1 = 0; exp_st2 = 0;
        for (int j = 0; j < 5; j++) begin
            apply(lu);
            push_b(S_LU, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_b() !== e) begin n_fail++; $display("FAIL sat_lu[%0d]: got %h want %h", j, obs_b(), e); end
            tick(1'b0);
            apply(md1);
            push_b(S_DEF, 1'b0);
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs_b() !== e) begin n_fail++; $display("FAIL sat_md[%0d]: got %h want %h", j, obs_b(), e); end
            tick(1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_back_to_back();
        test_md_priority();
        test_reset_mid_md();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It is the driving end of the pipeline-register `write_enable`/`flush` interface. It detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle mul/div occupancy of EX. From these it produces per-register write-enable and flush strobes plus the PC write-enable. It sits beside the ID and EX stages and drives the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- MD_LAT, default 4: total cycles a mul/div op occupies EX; legal range 1..16.
- CNT_W, default 16: width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX instruction redirects the PC (taken branch or jump).
- ex_md_start  in  1  EX instruction is a mul/div.
- pc_we  out  1  PC write-enable.
- ifid_we, ifid_flush  out  1 each  IF/ID write-enable and flush.
- idex_we, idex_flush  out  1 each  ID/EX write-enable and flush.
- exmem_we, exmem_flush  out  1 each  EX/MEM write-enable and flush.
- memwb_we  out  1  MEM/WB write-enable.
- md_busy  out  1  mul/div is holding EX this cycle.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.

## Operation
- Pipeline registers act on flush only when their we=1. Every asserted flush is therefore accompanied by we=1 on the same register. Flush inserts a bubble.
- The controller has two states.
  - RUN: normal issue.
  - MD_BUSY: mul/div counting down, using a 4-bit counter md_cnt.
- Default outputs (no hazard):
  - All we=1, all flush=0.
  - md_busy=0.
- Load-use, checked in RUN only.
  - Condition: ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1. Stalls exactly one cycle.
- Branch taken, in RUN.
  - Response: pc_we=1 (the target is muxed elsewhere), ifid_we=1, ifid_flush=1, idex_we=1, idex_flush=1.
  - Branch overrides a simultaneous load-use.
- Mul/div start, in RUN with ex_md_start=1 and MD_LAT≥2.
  - Stall this cycle: pc_we=ifid_we=idex_we=0, exmem_we=1, exmem_flush=1, memwb_we=1, md_busy=1.
  - Next state: md_cnt←MD_LAT−2, state←MD_BUSY.
- Mul/div with MD_LAT=1: no stall; state stays RUN.
- MD_BUSY with md_cnt≠0:
  - Same stall outputs as the start cycle.
  - md_cnt←md_cnt−1.
- MD_BUSY with md_cnt==0 (release cycle):
  - Default outputs; the op advances to MEM.
  - state←RUN.
  - ex_md_start, load-use and branch inputs are ignored in this cycle.
- Priority in RUN: mul/div start > branch taken > load-use > default. ex_md_start and ex_branch_taken are never both legitimately high. If both are high, mul/div wins and the branch is dropped.
- stall_cycles increments on each cycle with pc_we=0 and saturates at all-ones.

## Timing
- Outputs are combinational from state, md_cnt and the current inputs. There is zero-cycle latency from a hazard input to its strobe.
- A mul/div op holds EX for exactly MD_LAT cycles, giving MD_LAT−1 stall cycles.
- Reset: state=RUN, md_cnt=0, stall_cycles=0. While Rst=1, outputs show default values: all we=1, flushes 0, md_busy=0.
- Reset mid-MD_BUSY aborts the count immediately. The first cycle after reset is RUN.
- Back-to-back mul/div: the second op raises ex_md_start in the cycle after release and restarts the count.
- A load in release-cycle EX followed by a dependent instruction in ID is caught in the next RUN cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - State enum {RUN, MD_BUSY}.
  - Constant REG_ZERO=5'd0.
  - Strobe-bundle struct {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we}.
  - Constants STROBE_DEFAULT, STROBE_LOADUSE, STROBE_BRANCH, STROBE_MDSTALL.
- One sub-module, md_stall_timer, contains the state register, md_cnt and the md_busy output. The top level holds the hazard compare, the priority mux and the saturating counter.

## Test plan
- Load x5, then ID add reads x5 as rs2 → exactly 1 cycle with pc_we=0, ifid_we=0, idex_flush=1; stall_cycles=1.
- Load with ex_rd=0 and ID reads x0 → no stall; defaults held.
- ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_we=1, no stall.
- MD_LAT=4, ex_md_start held → 3 stall cycles with exmem_flush=1 and md_busy=1, then the release cycle shows defaults; stall_cycles=3.
- Rst pulsed during the second MD_BUSY cycle → outputs return to defaults asynchronously; stall_cycles=0; RUN after release.
- MD_LAT=1 and CNT_W=2 with 5 load-use stalls → no mul/div stalls; stall_cycles saturates at 3.
